// File: rtl/packet_dispatch_ctrl.sv
// packet_dispatch_ctrl: drains the payload FIFO after each decoded packet and routes words by command
module packet_dispatch_ctrl #(
    parameter int          ADDR_W    = 16,
    parameter int          FB_DEPTH  = 1024,
    parameter logic [31:0] CFG_RESET = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [1:0]        i_packet_command,
    input  logic              i_packet_done,
    input  logic              i_resync,
    input  logic              i_fifo_empty,
    input  logic [31:0]       i_fifo_rd_data,
    output logic              o_fifo_rd_en,
    output logic              o_fb_wr_en,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [31:0]       o_fb_wr_data,
    input  logic              i_fb_ready,
    output logic [31:0]       o_cfg_reg,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_error
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DATA, S_DONE} state_t;
    localparam logic [1:0] C_FRAME = 2'd1;
    localparam logic [1:0] C_CONFIG = 2'd2;
    localparam logic [1:0] C_RSVD = 2'd3;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);
    state_t     state;
    logic [1:0] cmd;
    logic       first;
    logic       wrap;
    assign wrap = o_fb_addr == LAST;
    // The read strobe and write data follow the state directly so data reaches the frame buffer in the cycle it is valid
    assign o_fifo_rd_en = state == S_READ && !i_fifo_empty;
    assign o_busy = state != S_IDLE;
    assign o_fb_wr_data = o_fb_wr_en ? i_fifo_rd_data : 32'h0;
    // Dispatch FSM; resync aborts any packet and outranks a simultaneous packet_done
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
            cmd <= 2'd0;
            first <= 1'b0;
            o_fb_wr_en <= 1'b0;
            o_fb_addr <= '0;
            o_cfg_reg <= CFG_RESET;
            o_frame_done <= 1'b0;
            o_error <= 1'b0;
        end else if (i_resync) begin
            state <= S_IDLE;
            o_fb_wr_en <= 1'b0;
            o_fb_addr <= '0;
            o_frame_done <= 1'b0;
            o_error <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (i_packet_done && state != S_IDLE) o_error <= 1'b1;
            case (state)
                S_IDLE: if (i_packet_done) begin
                    cmd <= i_packet_command;
                    first <= 1'b1;
                    o_fb_addr <= '0;
                    state <= S_READ;
                    if (i_packet_command == C_RSVD) o_error <= 1'b1;
                end
                S_READ: if (i_fifo_empty) begin
                    state <= S_DONE;
                    o_frame_done <= cmd == C_FRAME;
                end else begin
                    state <= S_DATA;
                    o_fb_wr_en <= cmd == C_FRAME;
                end
                S_DATA: if (cmd != C_FRAME || i_fb_ready) begin
                    state <= S_READ;
                    first <= 1'b0;
                    o_fb_wr_en <= 1'b0;
                    if (cmd == C_FRAME) begin
                        o_fb_addr <= wrap ? '0 : o_fb_addr + 1'b1;
                        if (wrap) o_error <= 1'b1;
                    end
                    if (cmd == C_CONFIG && first) o_cfg_reg <= i_fifo_rd_data;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_dispatch_ctrl.sv
// tb_packet_dispatch_ctrl: directed checks of packet dispatch, stalls, config, errors, resync and address wrap
module tb_packet_dispatch_ctrl;
    typedef struct {
        logic        done;
        logic        rdy;
        logic        busy;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic        fd;
        logic        err;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic resync = 1'b0;
    logic done0 = 1'b0;
    logic done4 = 1'b0;
    logic rdy = 1'b1;
    logic sel = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [31:0] rd_data = 32'h0;
    logic empty = 1'b1;
    logic rd0, wr0, busy0, fd0, err0, rd4, wr4, busy4, fd4, err4;
    logic [15:0] addr0, addr4;
    logic [31:0] wd0, cfg0, wd4, cfg4;
    logic [31:0] q[$];
    logic [15:0] log_a[$];
    logic [31:0] log_d[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_rd, n_fd, n_hold, bad_rd;
    logic prev_rd = 1'b0;
    logic [15:0] hold_addr = 16'hFFFF;
    logic [31:0] hold_data = 32'h0;
    vec_t vec[12];

    packet_dispatch_ctrl #(.ADDR_W(16), .FB_DEPTH(1024), .CFG_RESET(32'hC0FF_EE00)) dut (
        .i_clk(clk), .i_reset(rst), .i_packet_command(cmd), .i_packet_done(done0), .i_resync(resync),
        .i_fifo_empty(sel ? 1'b1 : empty), .i_fifo_rd_data(rd_data), .o_fifo_rd_en(rd0), .o_fb_wr_en(wr0),
        .o_fb_addr(addr0), .o_fb_wr_data(wd0), .i_fb_ready(rdy), .o_cfg_reg(cfg0), .o_busy(busy0),
        .o_frame_done(fd0), .o_error(err0));

    packet_dispatch_ctrl #(.ADDR_W(16), .FB_DEPTH(4), .CFG_RESET(32'h0)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_packet_command(cmd), .i_packet_done(done4), .i_resync(resync),
        .i_fifo_empty(sel ? empty : 1'b1), .i_fifo_rd_data(rd_data), .o_fifo_rd_en(rd4), .o_fb_wr_en(wr4),
        .o_fb_addr(addr4), .o_fb_wr_data(wd4), .i_fb_ready(rdy), .o_cfg_reg(cfg4), .o_busy(busy4),
        .o_frame_done(fd4), .o_error(err4));

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after a read strobe and holds until the next read
    always @(posedge clk) begin
        if ((sel ? rd4 : rd0) && q.size() > 0) rd_data <= q.pop_front();
        empty <= q.size() == 0;
    end

    // Monitor of the selected instance: reads, accepted writes, held words and frame_done pulses
    always @(negedge clk) begin
        if (sel ? rd4 : rd0) begin
            n_rd++;
            if (prev_rd || empty) bad_rd++;
        end
        prev_rd = sel ? rd4 : rd0;
        if ((sel ? wr4 : wr0) && rdy) begin
            log_a.push_back(sel ? addr4 : addr0);
            log_d.push_back(sel ? wd4 : wd0);
        end
        if ((sel ? wr4 : wr0) && (sel ? addr4 : addr0) == hold_addr && (sel ? wd4 : wd0) == hold_data) n_hold++;
        if (sel ? fd4 : fd0) n_fd++;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic clear_mon();
        n_rd = 0;
        n_fd = 0;
        n_hold = 0;
        bad_rd = 0;
        log_a.delete();
        log_d.delete();
    endtask

    task automatic run_pkt(input logic [1:0] c, input int sw, input int sl);
        int stalled = 0;
        clear_mon();
        cmd = c;
        rdy = 1'b1;
        if (sel) done4 = 1'b1; else done0 = 1'b1;
        step();
        done0 = 1'b0;
        done4 = 1'b0;
        for (int k = 0; k < 200 && (sel ? busy4 : busy0); k++) begin
            rdy = !((sel ? wr4 : wr0) && log_a.size() == sw && stalled < sl);
            if (!rdy) stalled++;
            step();
        end
        rdy = 1'b1;
        chk("pkt_timeout", {31'h0, sel ? busy4 : busy0}, 32'h0);
    endtask

    initial begin
        vec[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0,  1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 32'h0,  1'b0, 1'b0};
        vec[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 32'hA0, 1'b0, 1'b0};
        vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 32'h0,  1'b0, 1'b0};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 32'hA1, 1'b0, 1'b0};
        vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 32'h0,  1'b0, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 32'hA2, 1'b0, 1'b0};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 32'h0,  1'b0, 1'b0};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 32'hA3, 1'b0, 1'b0};
        vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 32'h0,  1'b0, 1'b0};
        vec[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 32'h0,  1'b1, 1'b0};
        vec[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 32'h0,  1'b0, 1'b0};
        clear_mon();
        @(negedge clk);
        chk("rst_rd", {31'h0, rd0}, 32'h0);
        chk("rst_wr", {31'h0, wr0}, 32'h0);
        chk("rst_addr", {16'h0, addr0}, 32'h0);
        chk("rst_wdata", wd0, 32'h0);
        chk("rst_cfg", cfg0, 32'hC0FF_EE00);
        chk("rst_busy", {31'h0, busy0}, 32'h0);
        chk("rst_fd", {31'h0, fd0}, 32'h0);
        chk("rst_err", {31'h0, err0}, 32'h0);
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) push(32'hA0 + i);
        step();
        cmd = 2'd1;
        for (int i = 0; i < 12; i++) begin
            done0 = vec[i].done;
            rdy = vec[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_busy", i), {31'h0, busy0}, {31'h0, vec[i].busy});
            chk($sformatf("v%0d_rd", i), {31'h0, rd0}, {31'h0, vec[i].rd});
            chk($sformatf("v%0d_wr", i), {31'h0, wr0}, {31'h0, vec[i].wr});
            chk($sformatf("v%0d_addr", i), {16'h0, addr0}, {16'h0, vec[i].addr});
            chk($sformatf("v%0d_data", i), wd0, vec[i].data);
            chk($sformatf("v%0d_fd", i), {31'h0, fd0}, {31'h0, vec[i].fd});
            chk($sformatf("v%0d_err", i), {31'h0, err0}, {31'h0, vec[i].err});
            step();
        end
        done0 = 1'b0;
        for (int i = 0; i < 3; i++) push(32'hB0 + i);
        hold_addr = 16'd1;
        hold_data = 32'hB1;
        step();
        run_pkt(2'd1, 1, 5);
        chk("stall_writes", log_a.size(), 3);
        chk("stall_reads", n_rd, 3);
        chk("stall_hold", n_hold, 6);
        chk("stall_fd", n_fd, 1);
        for (int i = 0; i < 3 && i < log_a.size(); i++) begin
            chk($sformatf("stall_a%0d", i), {16'h0, log_a[i]}, i);
            chk($sformatf("stall_d%0d", i), log_d[i], 32'hB0 + i);
        end
        hold_addr = 16'hFFFF;
        push(32'h1234_5678);
        push(32'hDEAD_BEEF);
        step();
        run_pkt(2'd2, 99, 0);
        chk("cfg_val", cfg0, 32'h1234_5678);
        chk("cfg_writes", log_a.size(), 0);
        chk("cfg_fd", n_fd, 0);
        chk("cfg_reads", n_rd, 2);
        chk("cfg_empty", {31'h0, empty}, 32'h1);
        chk("cfg_err", {31'h0, err0}, 32'h0);
        push(32'h1);
        push(32'h2);
        step();
        run_pkt(2'd3, 99, 0);
        chk("rsvd_reads", n_rd, 2);
        chk("rsvd_writes", log_a.size(), 0);
        chk("rsvd_err", {31'h0, err0}, 32'h1);
        chk("rsvd_cfg", cfg0, 32'h1234_5678);
        push(32'h3);
        step();
        run_pkt(2'd0, 99, 0);
        chk("nop_reads", n_rd, 1);
        chk("err_sticky", {31'h0, err0}, 32'h1);
        chk("rd_rules", bad_rd, 0);
        for (int i = 0; i < 3; i++) push(32'hC0 + i);
        step();
        cmd = 2'd1;
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        rdy = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rs_pre_wr", {31'h0, wr0}, 32'h1);
        chk("rs_pre_addr", {16'h0, addr0}, 32'h0);
        step();
        resync = 1'b1;
        done0 = 1'b1;
        step();
        resync = 1'b0;
        done0 = 1'b0;
        @(negedge clk);
        chk("rs_wr", {31'h0, wr0}, 32'h0);
        chk("rs_busy", {31'h0, busy0}, 32'h0);
        chk("rs_addr", {16'h0, addr0}, 32'h0);
        chk("rs_cfg", cfg0, 32'h1234_5678);
        chk("rs_err", {31'h0, err0}, 32'h0);
        n_hold = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            if (busy0) n_hold++;
        end
        chk("rs_no_start", n_hold, 0);
        rdy = 1'b1;
        q.delete();
        empty = 1'b1;
        step();
        sel = 1'b1;
        for (int i = 0; i < 6; i++) push(32'hE0 + i);
        step();
        run_pkt(2'd1, 99, 0);
        chk("wrap_writes", log_a.size(), 6);
        for (int i = 0; i < 6 && i < log_a.size(); i++) begin
            chk($sformatf("wrap_a%0d", i), {16'h0, log_a[i]}, i % 4);
            chk($sformatf("wrap_d%0d", i), log_d[i], 32'hE0 + i);
        end
        chk("wrap_err", {31'h0, err4}, 32'h1);
        chk("wrap_fd", n_fd, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
